sfp_alarm_ctrl: RTL

Downstream consumer of the SFP status filter: takes the debounced 8-port module-presence and LOS vectors, detects per-port changes, latches them into sticky write-1-to-clear event registers, counts LOS assertions per port, and drives a single maskable, rate-limited interrupt to the CPU interface. It sits between the SFP status filter and the CPU register/interrupt block.

---
 rtl/sfp_alarm_ctrl_if.sv | 32 +++
 rtl/sfp_alarm_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/sfp_alarm_ctrl_if.sv
// SFP alarm controller bus: debounced SFP status in, CPU-facing events/counter/irq out.
// master = status filter + CPU register block side, slave = sfp_alarm_ctrl.
// clk_100hz travels with the bus because it is a qualifier, not a clock.
interface sfp_alarm_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             clk_100hz;
  logic [7:0]       sfp_only_reg;
  logic [7:0]       sfp_los_reg;
  logic [15:0]      int_mask;
  logic             clr_we;
  logic             clr_sel;
  logic [7:0]       clr_data;
  logic             cnt_rd;
  logic [2:0]       cnt_sel;
  logic [7:0]       only_evt;
  logic [7:0]       los_evt;
  logic [CNT_W-1:0] cnt_data;
  logic             irq;

  modport master (
    output clk_100hz, sfp_only_reg, sfp_los_reg, int_mask,
    output clr_we, clr_sel, clr_data, cnt_rd, cnt_sel,
    input  only_evt, los_evt, cnt_data, irq
  );

  modport slave (
    input  clk_100hz, sfp_only_reg, sfp_los_reg, int_mask,
    input  clr_we, clr_sel, clr_data, cnt_rd, cnt_sel,
    output only_evt, los_evt, cnt_data, irq
  );
endinterface

// File: rtl/sfp_alarm_ctrl.sv
// SFP alarm controller: per-port change detect into sticky W1C event flags, optional
// saturating per-port LOS counters (SFP_ALARM_CNT_EN), maskable rate-limited irq.
// Latency: input change -> event flag 1 clk -> irq 2 clk; cnt_data 1 clk after cnt_rd.
// Ports: clk, rst (async active-high), bus (sfp_alarm_ctrl_if.slave). No backpressure.
module sfp_alarm_ctrl #(
  parameter int IRQ_HOLD = 10,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  sfp_alarm_ctrl_if.slave    bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ASSERT = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;

  localparam int HOLD_W = (IRQ_HOLD > 1) ? $clog2(IRQ_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(IRQ_HOLD);
  localparam bit HOLD_EN = (IRQ_HOLD != 0);

  logic [7:0]        only_prev_q, only_prev_d;
  logic [7:0]        los_prev_q,  los_prev_d;
  logic [7:0]        only_evt_q,  only_evt_d;
  logic [7:0]        los_evt_q,   los_evt_d;
  logic [1:0]        state_q,     state_d;
  logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
  logic              irq_q,       irq_d;
  logic [7:0]        only_clr, los_clr;
  logic              pend;

  // Change detect and sticky flags; the OR of the change term after the clear
  // makes a same-cycle set win over a clear.
  always_comb begin
    only_prev_d = bus.sfp_only_reg;
    los_prev_d  = bus.sfp_los_reg;
    only_clr    = (bus.clr_we && !bus.clr_sel) ? bus.clr_data : 8'h00;
    los_clr     = (bus.clr_we &&  bus.clr_sel) ? bus.clr_data : 8'h00;
    only_evt_d  = (only_evt_q & ~only_clr) | (bus.sfp_only_reg ^ only_prev_q);
    los_evt_d   = (los_evt_q  & ~los_clr)  | (bus.sfp_los_reg  ^ los_prev_q);
  end

  assign pend = |({los_evt_q, only_evt_q} & ~bus.int_mask);

  // irq FSM: after a deassertion irq stays low for IRQ_HOLD slow ticks so a
  // flapping link cannot storm the CPU; events still latch meanwhile.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pend) state_d = S_ASSERT;
      end
      S_ASSERT: begin
        if (!pend) begin
          if (HOLD_EN) begin
            state_d    = S_HOLD;
            hold_cnt_d = HOLD_INIT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == '0)   state_d    = S_IDLE;
        else if (bus.clk_100hz) hold_cnt_d = hold_cnt_q - HOLD_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    irq_d = (state_d == S_ASSERT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      only_prev_q <= 8'hff;
      los_prev_q  <= 8'hff;
      only_evt_q  <= 8'h00;
      los_evt_q   <= 8'h00;
      state_q     <= S_IDLE;
      hold_cnt_q  <= '0;
      irq_q       <= 1'b0;
    end else begin
      only_prev_q <= only_prev_d;
      los_prev_q  <= los_prev_d;
      only_evt_q  <= only_evt_d;
      los_evt_q   <= los_evt_d;
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      irq_q       <= irq_d;
    end
  end

  assign bus.only_evt = only_evt_q;
  assign bus.los_evt  = los_evt_q;
  assign bus.irq      = irq_q;

`ifdef SFP_ALARM_CNT_EN
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
  logic [CNT_W-1:0] cnt_data_q, cnt_data_d;
  logic [7:0]       los_rise;

  // LOS assertions only count on ports with a module plugged in. The read
  // clears first and the increment is applied on top, so an edge coinciding
  // with a read leaves the counter at 1 instead of being lost.
  always_comb begin
    cnt_d      = cnt_q;
    cnt_data_d = cnt_data_q;
    los_rise   = bus.sfp_los_reg & ~los_prev_q & ~bus.sfp_only_reg;
    if (bus.cnt_rd) begin
      cnt_data_d         = cnt_q[bus.cnt_sel];
      cnt_d[bus.cnt_sel] = '0;
    end
    for (int p = 0; p < 8; p++) begin
      if (los_rise[p] && (cnt_d[p] != {CNT_W{1'b1}})) cnt_d[p] = cnt_d[p] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '{default: '0};
      cnt_data_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      cnt_data_q <= cnt_data_d;
    end
  end

  assign bus.cnt_data = cnt_data_q;
`else
  logic unused_cnt;
  assign unused_cnt   = ^{bus.cnt_rd, bus.cnt_sel};
  assign bus.cnt_data = '0;
`endif

endmodule
